// File: rtl/fifo_rd_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_pkg
// Shared constants and helpers for the FIFO read-side byte packer.
//   FIFO_DATA_W        : byte width delivered by the async FIFO (fixed at 8)
//   PACK_BYTES_DEFAULT : default number of bytes packed per output word
//   MAX_PACK           : largest supported PACK_BYTES
//   keep_mask(n)       : mask with the low n bits set (n = 0..MAX_PACK)
// -----------------------------------------------------------------------------
package fifo_rd_packer_pkg;

    localparam int FIFO_DATA_W        = 8;
    localparam int PACK_BYTES_DEFAULT = 4;
    localparam int MAX_PACK           = 8;

    // Returned at MAX_PACK width; callers cast down to their lane count.
    function automatic logic [MAX_PACK-1:0] keep_mask(input logic [3:0] n);
        logic [MAX_PACK-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PACK; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_outreg.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_outreg
// Output holding register for the packer's valid/ready master stream.
// A load captures a new word and raises m_valid; an accept without a
// same-cycle load drops m_valid. Payload holds while m_valid && !m_ready.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture load_* this cycle (caller guarantees slot free)
//   load_data/keep/last : word being handed over
//   m_ready           : downstream accept
//   m_valid/m_data/m_keep/m_last : registered stream outputs
// -----------------------------------------------------------------------------
module fifo_rd_packer_outreg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            // Covers both an empty slot and accept-and-reload in one cycle.
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= load_keep;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Read-side consumer of the async FIFO. Pops bytes through the FIFO's
// r_en/data_out/empty interface, packs PACK_BYTES of them (first byte in
// lane 0) and offers the word on a valid/ready stream. A flush pulse closes
// the current partial word with a keep mask and m_last=1.
// Ports:
//   rclk, rrst   : read clock, asynchronous active-low reset
//   fifo_empty   : FIFO empty flag
//   fifo_r_en    : FIFO read enable (combinational)
//   fifo_data    : FIFO data, valid one cycle after fifo_r_en
//   flush        : single-cycle request to emit the partial word
//   m_valid/m_ready/m_data/m_keep/m_last : output word stream
//   busy         : any byte in flight, assembling, awaiting accept, or flush pending
// -----------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int PACK_BYTES = PACK_BYTES_DEFAULT,
    parameter int DATA_W     = FIFO_DATA_W,
    parameter int CNT_W      = $clog2(PACK_BYTES + 1)
) (
    input  logic                         rclk,
    input  logic                         rrst,
    input  logic                         fifo_empty,
    output logic                         fifo_r_en,
    input  logic [DATA_W-1:0]            fifo_data,
    input  logic                         flush,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_W*PACK_BYTES-1:0] m_data,
    output logic [PACK_BYTES-1:0]        m_keep,
    output logic                         m_last,
    output logic                         busy
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK_BYTES);

    logic [CNT_W-1:0]                      count;
    logic                                  inflight;
    logic                                  flush_pend;
    logic [PACK_BYTES-1:0][DATA_W-1:0]     asm_q;

    logic [CNT_W:0]          occupancy;
    logic                    slot_free;
    logic                    full_xfer;
    logic                    flush_ready;
    logic                    part_xfer;
    logic                    load;
    logic [PACK_BYTES-1:0]   load_keep;

    // Bytes already in the assembly register plus the one on its way.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

    // Gated by rrst so the enable is low while reset is held, even though
    // it is otherwise combinational from fifo_empty.
    assign fifo_r_en = rrst && !fifo_empty && !flush_pend
                       && (occupancy < {1'b0, CNT_FULL});

    assign slot_free   = !m_valid || m_ready;
    assign full_xfer   = (count == CNT_FULL) && slot_free;
    // A flush waits for the in-flight byte to land before closing the word.
    assign flush_ready = flush_pend && !inflight;
    assign part_xfer   = flush_ready && (count != '0) && (count != CNT_FULL) && slot_free;
    assign load        = full_xfer || part_xfer;

    // keep_mask(PACK_BYTES) is all ones, so one expression serves both cases.
    assign load_keep = PACK_BYTES'(keep_mask(4'(count)));

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            count      <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            inflight <= fifo_r_en;

            // Issue gating keeps a landing byte and a transfer from
            // ever coinciding, so the two branches are exclusive.
            if (load) begin
                count <= '0;
            end else if (inflight) begin
                count <= count + CNT_W'(1);
            end

            // A flush seen while one is already pending is dropped.
            if (!flush_pend) begin
                flush_pend <= flush;
            end else if (load || (flush_ready && count == '0)) begin
                flush_pend <= 1'b0;
            end
        end
    end

    // Lane insertion: the landing byte goes into lane[count].
    for (genvar i = 0; i < PACK_BYTES; i++) begin : g_lane
        always_ff @(posedge rclk or negedge rrst) begin
            if (!rrst) begin
                asm_q[i] <= '0;
            end else if (load) begin
                asm_q[i] <= '0;
            end else if (inflight && count == CNT_W'(i)) begin
                asm_q[i] <= fifo_data;
            end
        end
    end

    fifo_rd_packer_outreg #(
        .DATA_W (DATA_W * PACK_BYTES),
        .KEEP_W (PACK_BYTES)
    ) u_outreg (
        .clk       (rclk),
        .rst_n     (rrst),
        .load      (load),
        .load_data (asm_q),
        .load_keep (load_keep),
        .load_last (flush_pend),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last)
    );

    assign busy = inflight || (count != '0) || m_valid || flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

    localparam int P = 4;

    logic          rclk = 1'b0;
    logic          rrst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_r_en;
    logic [7:0]    fifo_data = 8'h00;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [8*P-1:0] m_data;
    logic [P-1:0]  m_keep;
    logic          m_last;
    logic          busy;

    fifo_rd_packer #(.PACK_BYTES(P)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .busy       (busy)
    );

    always #5 rclk = ~rclk;

    typedef struct packed {
        logic [8*P-1:0] d;
        logic [P-1:0]   k;
        logic           l;
    } word_t;

    logic [7:0] fifo_q[$];   // bytes sitting in the modelled FIFO
    logic [7:0] acc[$];      // bytes popped but not yet assigned to a word
    word_t      exp_q[$];    // expected output words, in order

    int n_vec = 0;
    int n_err = 0;
    int ren_cnt = 0;
    int empty_mode = 0;      // 0: plain, 1: force empty every 3 cycles, 2: random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: every P popped bytes make a word; a flush takes
    // whatever has been popped up to and including the flush cycle.
    function automatic void emit(input bit last);
        word_t w;
        w.d = '0;
        for (int i = 0; i < acc.size(); i++) w.d[8*i +: 8] = acc[i];
        w.k = P'((1 << acc.size()) - 1);
        w.l = last;
        exp_q.push_back(w);
        acc.delete();
    endfunction

    // FIFO model plus stream-level reference update.
    initial begin : fifo_model
        bit ren_s, fl_s;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge rclk);
            #2;
            ren_s = fifo_r_en;
            fl_s  = flush;
            if (fifo_empty) check("ren_while_empty", 64'(fifo_r_en), 64'd0);
            @(posedge rclk);
            #1;
            if (ren_s) begin
                if (fifo_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL fifo_underflow: read with %0d bytes queued, need at least 1", fifo_q.size());
                end else begin
                    fifo_data = fifo_q.pop_front();
                    acc.push_back(fifo_data);
                    ren_cnt++;
                    if (acc.size() == P) emit(1'b0);
                end
            end
            if (fl_s && acc.size() > 0) emit(1'b1);
            cyc++;
            case (empty_mode)
                1:       fifo_empty = (fifo_q.size() == 0) || (((cyc / 3) % 2) == 1);
                2:       fifo_empty = (fifo_q.size() == 0) || ($urandom_range(0, 2) == 0);
                default: fifo_empty = (fifo_q.size() == 0);
            endcase
        end
    end

    // Scoreboard monitor and hold-stability check.
    initial begin : monitor
        bit    stall;
        word_t held, e;
        stall = 1'b0;
        forever begin
            @(negedge rclk);
            if (!rrst) begin
                stall = 1'b0;
            end else begin
                if (stall)
                    check("hold_stable", 64'({m_valid, m_data, m_keep, m_last}), 64'({1'b1, held}));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h/%h/%b expected none", m_data, m_keep, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", 64'({m_data, m_keep, m_last}), 64'(e));
                    end
                end
                stall = m_valid && !m_ready;
                held  = {m_data, m_keep, m_last};
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic pulse_flush();
        @(posedge rclk); #1 flush = 1'b1;
        @(posedge rclk); #1 flush = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int c;
        c = 0;
        repeat (3) @(negedge rclk);
        while ((busy || exp_q.size() != 0 || fifo_q.size() != 0) && c < maxc) begin
            @(negedge rclk);
            c++;
        end
        check(name, 64'(c < maxc), 64'd1);
    endtask

    initial begin : stim
        int base, c;

        // Reset state
        repeat (3) @(posedge rclk);
        #1;
        check("rst_r_en",   64'(fifo_r_en), 64'd0);
        check("rst_valid",  64'(m_valid),   64'd0);
        check("rst_data",   64'(m_data),    64'd0);
        check("rst_keep",   64'(m_keep),    64'd0);
        check("rst_last",   64'(m_last),    64'd0);
        check("rst_busy",   64'(busy),      64'd0);
        rrst = 1'b1;
        m_ready = 1'b1;

        // Basic pack
        base = ren_cnt;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_drain("basic_drain", 100);
        check("basic_ren_pulses", 64'(ren_cnt - base), 64'd4);

        // Partial flush, busy drops the cycle after acceptance
        push(8'hAA); push(8'hBB);
        repeat (8) @(negedge rclk);
        pulse_flush();
        c = 0;
        while (!(m_valid && m_ready) && c < 20) begin @(negedge rclk); c++; end
        check("pflush_seen", 64'(c < 20), 64'd1);
        @(posedge rclk); #1;
        check("pflush_busy_drop", 64'(busy), 64'd0);
        wait_drain("pflush_drain", 100);

        // Flush in the same cycle as the 3rd read; a 4th byte must wait
        base = ren_cnt;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        c = 0;
        @(negedge rclk);
        while (!(fifo_r_en && ren_cnt == base + 2) && c < 20) begin @(negedge rclk); c++; end
        check("inflight_hit", 64'(c < 20), 64'd1);
        flush = 1'b1;
        @(posedge rclk); #1 flush = 1'b0;
        repeat (2) begin
            @(negedge rclk);
            check("inflight_no_ren", 64'(fifo_r_en), 64'd0);
        end
        repeat (8) @(negedge rclk);
        check("inflight_ren_cnt", 64'(ren_cnt - base), 64'd4);
        pulse_flush();
        wait_drain("inflight_drain", 100);

        // Backpressure: two words fill, then reads stop
        m_ready = 1'b0;
        base = ren_cnt;
        for (int i = 0; i < 12; i++) push(8'(i));
        repeat (30) @(negedge rclk);
        check("bp_valid", 64'(m_valid), 64'd1);
        check("bp_data",  64'(m_data),  64'h03020100);
        check("bp_reads", 64'(ren_cnt - base), 64'd8);
        repeat (3) begin
            @(negedge rclk);
            check("bp_no_ren", 64'(fifo_r_en), 64'd0);
        end
        @(posedge rclk); #1 m_ready = 1'b1;
        wait_drain("bp_drain", 200);

        // Empty flag toggling every 3 cycles
        empty_mode = 1;
        for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)));
        wait_drain("toggle_drain", 400);
        empty_mode = 0;

        // Flush with nothing assembled: no output
        pulse_flush();
        repeat (6) begin
            @(negedge rclk);
            check("zflush_no_valid", 64'(m_valid), 64'd0);
        end
        check("zflush_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-word
        push(8'h5A); push(8'hA5);
        repeat (8) @(negedge rclk);
        check("mid_busy", 64'(busy), 64'd1);
        @(posedge rclk); #3 rrst = 1'b0;
        acc.delete();
        #1;
        check("mid_rst_r_en",  64'(fifo_r_en), 64'd0);
        check("mid_rst_valid", 64'(m_valid),   64'd0);
        check("mid_rst_data",  64'(m_data),    64'd0);
        check("mid_rst_keep",  64'(m_keep),    64'd0);
        check("mid_rst_last",  64'(m_last),    64'd0);
        check("mid_rst_busy",  64'(busy),      64'd0);
        @(posedge rclk); #1 rrst = 1'b1;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_drain("post_rst_drain", 100);

        // Random bytes, random empty, random backpressure
        empty_mode = 2;
        for (int i = 0; i < 48; i++) push(8'($urandom_range(0, 255)));
        c = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && c < 3000) begin
            @(posedge rclk); #1 m_ready = ($urandom_range(0, 1) == 1);
            c++;
        end
        check("rand_done", 64'(c < 3000), 64'd1);
        @(posedge rclk); #1 m_ready = 1'b1;
        empty_mode = 0;
        wait_drain("rand_drain", 200);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
